shift_add_mult: RTL and testbench

Sequential 4x4 unsigned multiplier controller: one 4-bit ripple-carry full-adder datapath, reused over four add/shift iterations to form an 8-bit product. Sits between switch/key inputs and the HEX display path. Accepts a start pulse, reports busy, and pulses done when the registered product is valid.

---
 rtl/shift_add_mult.sv | 91 +++++++++
 tb/tb_shift_add_mult.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_mult
// Description : Sequential 4x4 unsigned shift-add multiplier that reuses one
//               4-bit ripple-carry adder over four iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mult (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_m;
  logic [3:0]  r_a;
  logic [3:0]  r_q;
  logic        r_c;
  logic [1:0]  r_cnt;
  logic [7:0]  r_p;

  logic [4:0]  w_carry;
  logic [3:0]  w_add;
  logic [4:0]  w_sum;

  // C is cleared on load and by every shift, so it serves as the zero carry-in.
  assign w_carry[0] = r_c;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_fa
      assign w_add[i]       = r_a[i] ^ r_m[i] ^ w_carry[i];
      assign w_carry[i + 1] = (r_a[i] & r_m[i]) | (r_a[i] & w_carry[i]) |
                              (r_m[i] & w_carry[i]);
    end
  endgenerate

  assign w_sum = r_q[0] ? {w_carry[4], w_add} : {1'b0, r_a};

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_m     <= 4'd0;
      r_a     <= 4'd0;
      r_q     <= 4'd0;
      r_c     <= 1'b0;
      r_cnt   <= 2'd0;
      r_p     <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_a     <= 4'd0;
            r_c     <= 1'b0;
            r_cnt   <= 2'd0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          // Right shift of {carry, A, Q}; the adder carry lands in A[3].
          {r_c, r_a, r_q} <= {1'b0, w_sum, r_q[3:1]};
          r_cnt           <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_p     <= {w_sum, r_q[3:1]};
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign product = r_p;
  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_add_mult
// Description : Directed self-checking bench for shift_add_mult.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  shift_add_mult dut (
    .clock   (clock),
    .resetn  (resetn),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Pulses start for one edge (called at a negedge, DUT idle) and observes a window.
  task automatic run_op(input logic [3:0] op_a, input logic [3:0] op_b, input int window,
                        output int n_done, output int idx_done, output int n_busy,
                        output logic [7:0] p_done);
    a = op_a; b = op_b; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    n_done = 0; idx_done = -1; n_busy = 0; p_done = 8'hxx;
    for (int i = 0; i < window; i++) begin
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (idx_done < 0) idx_done = i;
        p_done = product;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    int n_done;
    resetn = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (product !== 8'h00) begin failures++; $display("FAIL reset_product: got %h want 00", product); end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_flags: got busy=%b done=%b want 0/0", busy, done);
    end
    resetn = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin failures++; $display("FAIL idle_done: got %0d pulses want 0", n_done); end
    checks++;
    if (product !== 8'h00 || busy !== 1'b0) begin
      failures++; $display("FAIL idle_state: got product=%h busy=%b want 00/0", product, busy);
    end
  endtask

  task automatic test_basic();
    int n_done, idx_done, n_busy;
    logic [7:0] p_done;
    run_op(4'd7, 4'd5, 26, n_done, idx_done, n_busy, p_done);
    checks++;
    if (n_busy !== 5) begin failures++; $display("FAIL basic_busy: got %0d cycles want 5", n_busy); end
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
    checks++;
    if (idx_done !== 4) begin failures++; $display("FAIL basic_latency: got %0d want 4", idx_done); end
    checks++;
    if (p_done !== 8'h23) begin failures++; $display("FAIL basic_product: got %h want 23", p_done); end
    checks++;
    if (product !== 8'h23) begin failures++; $display("FAIL basic_hold: got %h want 23", product); end
  endtask

  task automatic test_corners();
    logic [3:0] ta [4] = '{4'd15, 4'd0, 4'd9, 4'd1};
    logic [3:0] tb [4] = '{4'd15, 4'd9, 4'd0, 4'd15};
    logic [7:0] te [4] = '{8'hE1, 8'h00, 8'h00, 8'h0F};
    int n_done, idx_done, n_busy;
    logic [7:0] p_done;
    for (int k = 0; k < 4; k++) begin
      run_op(ta[k], tb[k], 8, n_done, idx_done, n_busy, p_done);
      checks++;
      if (p_done !== te[k]) begin
        failures++; $display("FAIL corner_%0dx%0d: got %h want %h", ta[k], tb[k], p_done, te[k]);
      end
      checks++;
      if (n_done !== 1 || idx_done !== 4) begin
        failures++; $display("FAIL corner_done_%0d: got count=%0d idx=%0d want 1/4", k, n_done, idx_done);
      end
    end
  endtask

  task automatic test_isolation();
    int n_done;
    logic [7:0] p_done;
    a = 4'd3; b = 4'd4; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    n_done = 0; p_done = 8'hxx;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin a = 4'd15; b = 4'd15; start = 1'b1; end
      if (i == 2) start = 1'b0;
      if (done) begin n_done++; p_done = product; end
      @(negedge clock);
    end
    checks++;
    if (p_done !== 8'h0C) begin failures++; $display("FAIL iso_product: got %h want 0C", p_done); end
    checks++;
    if (n_done !== 1) begin failures++; $display("FAIL iso_done_count: got %0d want 1", n_done); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL iso_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] na [3] = '{4'd2, 4'd6, 4'd15};
    logic [3:0] nb [3] = '{4'd3, 4'd6, 4'd1};
    logic [7:0] ne [3] = '{8'h06, 8'h24, 8'h0F};
    int idx [3];
    logic [7:0] got [3];
    int n_done;
    n_done = 0;
    a = na[0]; b = nb[0]; start = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done) begin
        if (n_done < 3) begin idx[n_done] = i; got[n_done] = product; end
        n_done++;
        if (n_done < 3) begin a = na[n_done]; b = nb[n_done]; end
        else start = 1'b0;
      end
    end
    checks++;
    if (n_done !== 3) begin failures++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
    if (n_done >= 3) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got[k] !== ne[k]) begin
          failures++; $display("FAIL b2b_product_%0d: got %h want %h", k, got[k], ne[k]);
        end
      end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (idx[k] - idx[k-1] !== 6) begin
          failures++; $display("FAIL b2b_spacing_%0d: got %0d want 6", k, idx[k] - idx[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n_done, idx_done, n_busy;
    logic [7:0] p_done;
    // Flush any previous product so the mid-op reset must clear it.
    a = 4'd13; b = 4'd11; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) n_done++;
      @(negedge clock);
    end
    checks++;
    if (n_done !== 0) begin failures++; $display("FAIL midrst_done: got %0d pulses want 0", n_done); end
    checks++;
    if (product !== 8'h00) begin failures++; $display("FAIL midrst_product: got %h want 00", product); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", busy); end
    run_op(4'd13, 4'd11, 8, n_done, idx_done, n_busy, p_done);
    checks++;
    if (p_done !== 8'h8F || n_done !== 1) begin
      failures++; $display("FAIL midrst_rerun: got %h count=%0d want 8F count=1", p_done, n_done);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetn = 1'b0; start = 1'b0; a = 4'd0; b = 4'd0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_corners();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
